// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter that sequences single-cycle
// accesses to the shared DataMemory and returns a registered response.
// Timing: accept at edge k, memory access in cycle k..k+1, read data captured
// at k+1, resp_valid pulses in the cycle after edge k+2.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter bit          RR_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [1:0]  req_we,
  input  logic [2:0]  req_ctrl0,
  input  logic [2:0]  req_ctrl1,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Address,
  output logic [31:0] DataWr,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  input  logic [31:0] DataRd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        gport;
  logic        g_we;
  logic        g_err;

  logic        sel;
  logic [1:0]  sel_mask;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_ctrl;
  logic        sel_we;
  logic        sel_err;
  logic [2:0]  size;
  logic        illegal;
  logic        misalign;
  logic [32:0] last_byte;

  // Pick the port to serve this IDLE cycle and check its request for errors.
  always_comb begin
    sel = 1'b0;
    case (req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = RR_EN ? ~last_grant : 1'b0;
      default: sel = 1'b0;
    endcase
    sel_mask  = (req_valid == 2'b00) ? 2'b00 : (sel ? 2'b10 : 2'b01);
    sel_addr  = sel ? req_addr1  : req_addr0;
    sel_wdata = sel ? req_wdata1 : req_wdata0;
    sel_ctrl  = sel ? req_ctrl1  : req_ctrl0;
    sel_we    = req_we[sel];

    size    = 3'd1;
    illegal = 1'b0;
    case (sel_ctrl)
      3'b000, 3'b100: size = 3'd1;
      3'b001, 3'b101: size = 3'd2;
      3'b010:         size = 3'd4;
      default:        illegal = 1'b1;
    endcase
    misalign  = ((size == 3'd2) && sel_addr[0]) ||
                ((size == 3'd4) && (sel_addr[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    last_byte = {1'b0, sel_addr} + 33'(size) - 33'd1;
    sel_err   = illegal || misalign || (last_byte >= 33'(MEM_BYTES));
  end

  // Only the selected port sees ready, and only while idle and out of reset.
  assign req_ready = ((state == IDLE) && !rst) ? sel_mask : 2'b00;

  // Sequencer: accept, drive memory for one cycle, capture, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gport      <= 1'b0;
      g_we       <= 1'b0;
      g_err      <= 1'b0;
      resp_valid <= 2'b00;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      Address    <= 32'h0;
      DataWr     <= 32'h0;
      DMWr       <= 1'b0;
      DMCtrl     <= 3'b010;
    end else begin
      resp_valid <= 2'b00;
      DMWr       <= 1'b0;
      case (state)
        IDLE: begin
          if ((req_valid & req_ready) != 2'b00) begin
            state      <= ACCESS;
            gport      <= sel;
            last_grant <= sel;
            g_we       <= sel_we;
            g_err      <= sel_err;
            Address    <= sel_addr;
            DataWr     <= sel_wdata;
            DMCtrl     <= sel_ctrl;
            DMWr       <= sel_we & ~sel_err;
          end
        end
        ACCESS: begin
          resp_rdata <= (!g_we && !g_err) ? DataRd : 32'h0;
          resp_err   <= g_err;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= gport ? 2'b10 : 2'b01;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a
// little-endian byte memory, plus a fixed-priority instance sharing inputs.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  req_we;
  logic [2:0]  req_ctrl0, req_ctrl1;

  logic [1:0]  rr_ready, rr_resp_valid, fp_ready, fp_resp_valid;
  logic [31:0] rr_rdata, fp_rdata, rr_addr, fp_addr, rr_wd, fp_wd, rr_rd;
  logic        rr_err, fp_err, rr_dmwr, fp_dmwr;
  logic [2:0]  rr_ctrl, fp_ctrl;

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.MEM_BYTES(1024), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_we(req_we),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .resp_valid(rr_resp_valid), .resp_rdata(rr_rdata), .resp_err(rr_err),
    .Address(rr_addr), .DataWr(rr_wd), .DMWr(rr_dmwr), .DMCtrl(rr_ctrl),
    .DataRd(rr_rd));

  dmem_arbiter #(.MEM_BYTES(1024), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_we(req_we),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .resp_valid(fp_resp_valid), .resp_rdata(fp_rdata), .resp_err(fp_err),
    .Address(fp_addr), .DataWr(fp_wd), .DMWr(fp_dmwr), .DMCtrl(fp_ctrl),
    .DataRd(32'h0));

  always #5 clk = ~clk;

  // Behavioural DataMemory: little-endian bytes, sized writes, extended reads.
  logic [7:0] mem [0:1023];

  function automatic logic [7:0] rb(input logic [31:0] a);
    return (a < 32'd1024) ? mem[a[9:0]] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rr_dmwr) begin
      mem[rr_addr[9:0]] <= rr_wd[7:0];
      if (rr_ctrl[1:0] != 2'b00) mem[rr_addr[9:0] + 10'd1] <= rr_wd[15:8];
      if (rr_ctrl[1:0] == 2'b10) begin
        mem[rr_addr[9:0] + 10'd2] <= rr_wd[23:16];
        mem[rr_addr[9:0] + 10'd3] <= rr_wd[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = rb(rr_addr);
    b1 = rb(rr_addr + 32'd1);
    b2 = rb(rr_addr + 32'd2);
    b3 = rb(rr_addr + 32'd3);
    case (rr_ctrl)
      3'b000:  rr_rd = {{24{b0[7]}}, b0};
      3'b100:  rr_rd = {24'h0, b0};
      3'b001:  rr_rd = {{16{b1[7]}}, b1, b0};
      3'b101:  rr_rd = {16'h0, b1, b0};
      3'b010:  rr_rd = {b3, b2, b1, b0};
      default: rr_rd = 32'h0;
    endcase
  end

  // Responses must never go to both ports at once.
  always @(negedge clk) begin
    if (rr_resp_valid == 2'b11 || fp_resp_valid == 2'b11) begin
      fails++;
      $display("FAIL dual_resp: rr=%b fp=%b, required one-hot or zero",
               rr_resp_valid, fp_resp_valid);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        p;
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // One request on port p; checks the access cycle and response timing.
  task automatic do_req(input string tag, input logic p, input logic we,
                        input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int n;
    if (p) begin req_addr1 = addr; req_wdata1 = wdata; req_ctrl1 = ctrl; end
    else   begin req_addr0 = addr; req_wdata0 = wdata; req_ctrl0 = ctrl; end
    req_we[p]    = we;
    req_valid[p] = 1'b1;
    #1;
    n = 0;
    while (!rr_ready[p] && n < 20) begin @(negedge clk); #1; n++; end
    chk({tag, "_ready"}, 32'(rr_ready[p]), 32'd1);
    if (!rr_ready[p]) begin req_valid[p] = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid[p] = 1'b0;
    chk({tag, "_dmwr"},  32'(rr_dmwr), 32'(we & ~exp_err));
    chk({tag, "_addr"},  rr_addr, addr);
    chk({tag, "_ctrl"},  32'(rr_ctrl), 32'(ctrl));
    chk({tag, "_wdata"}, rr_wd, wdata);
    chk({tag, "_busy"},  32'(rr_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_dmwr_off"}, 32'(rr_dmwr), 32'd0);
    chk({tag, "_no_early_resp"}, 32'(rr_resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_resp_valid"}, 32'(rr_resp_valid), p ? 32'd2 : 32'd1);
    chk({tag, "_rdata"}, rr_rdata, exp_rdata);
    chk({tag, "_err"},   32'(rr_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_resp_pulse"}, 32'(rr_resp_valid), 32'd0);
  endtask

  vec_t vecs [18];

  initial begin
    int n;
    logic [1:0] prev;

    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'd12,         32'h0000FFFC, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 3'b010, 32'd12,         32'h0,        32'h0000FFFC, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 3'b000, 32'd5,          32'h000000AB, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'b100, 32'd5,          32'h0,        32'h000000AB, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'd12,         32'h0,        32'h0000FFFC, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 3'b001, 32'd13,         32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3'b011, 32'd0,          32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'd1022,       32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'd1020,       32'h12345678, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'd1020,       32'h0,        32'h12345678, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'd1021,       32'hDEADBEEF, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 1'b0, 3'b010, 32'd1020,       32'h0,        32'h12345678, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'b001, 32'd14,         32'h0000BEEF, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'd12,         32'h0,        32'hBEEFFFFC, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 3'b010, 32'hFFFFFFFC,   32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b1, 1'b0, 3'b000, 32'd1023,       32'h0,        32'h00000012, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 3'b101, 32'd1022,       32'h0,        32'h00001234, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 3'b000, 32'd1024,       32'h000000CC, 32'h0,        1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    clk = 1'b0; rst = 1'b1;
    req_valid = 2'b11; req_we = 2'b00;
    req_addr0 = 32'h0; req_addr1 = 32'h0; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
    req_ctrl0 = 3'b010; req_ctrl1 = 3'b010;

    // Reset state, with both ports requesting
    #12;
    chk("rst_ready",    32'(rr_ready), 32'd0);
    chk("rst_fp_ready", 32'(fp_ready), 32'd0);
    chk("rst_resp",     32'(rr_resp_valid), 32'd0);
    chk("rst_rdata",    rr_rdata, 32'h0);
    chk("rst_err",      32'(rr_err), 32'd0);
    chk("rst_addr",     rr_addr, 32'h0);
    chk("rst_wd",       rr_wd, 32'h0);
    chk("rst_dmwr",     32'(rr_dmwr), 32'd0);
    chk("rst_dmctrl",   32'(rr_ctrl), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Continuous contention: rr alternates 0,1,0,1; fixed priority always 0
    req_addr1 = 32'd4;
    n = 0;
    prev = 2'b00;
    for (int g = 0; g < 4; g++) begin
      while (rr_ready == 2'b00 && n < 10) begin @(negedge clk); #1; n++; end
      chk($sformatf("rr_grant%0d", g), 32'(rr_ready), (g % 2 == 1) ? 32'd2 : 32'd1);
      chk($sformatf("fp_grant%0d", g), 32'(fp_ready), 32'd1);
      if (g > 0) begin
        chk($sformatf("rr_gap%0d", g), 32'(n), 32'd3);
        chk($sformatf("rr_resp_port%0d", g), 32'(rr_resp_valid), 32'(prev));
        chk($sformatf("fp_resp_port%0d", g), 32'(fp_resp_valid), 32'd1);
      end
      prev = rr_ready;
      @(posedge clk);
      @(negedge clk); #1;
      n = 1;
    end
    req_valid[0] = 1'b0;
    while (fp_ready == 2'b00 && n < 10) begin @(negedge clk); #1; n++; end
    chk("fp_port1_after_drop", 32'(fp_ready), 32'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Table of single requests
    for (int i = 0; i < 18; i++)
      do_req($sformatf("v%0d", i), vecs[i].p, vecs[i].we, vecs[i].ctrl,
             vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);

    // Reset in the middle of a store's access cycle
    req_addr0 = 32'd100; req_wdata0 = 32'h00000055; req_ctrl0 = 3'b010;
    req_we[0] = 1'b1; req_valid[0] = 1'b1;
    #1;
    chk("rstmid_ready", 32'(rr_ready), 32'd1);
    @(posedge clk);
    #2;
    chk("rstmid_dmwr_before", 32'(rr_dmwr), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_dmwr_cleared", 32'(rr_dmwr), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_no_resp%0d", c), 32'(rr_resp_valid), 32'd0);
    end
    do_req("post_rst_ld0", 1'b0, 1'b0, 3'b010, 32'd100, 32'h0, 32'h0, 1'b0);
    do_req("post_rst_st",  1'b0, 1'b1, 3'b010, 32'd100, 32'h77, 32'h0, 1'b0);
    do_req("post_rst_ld1", 1'b1, 1'b0, 3'b010, 32'd100, 32'h0, 32'h77, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the shared DataMemory block. The core load/store unit (port 0) and the DMA/debug loader (port 1) issue valid/ready requests. The arbiter grants one requester at a time and drives the memory's Address/DataWr/DMWr/DMCtrl inputs for exactly one access cycle. It then returns registered read data and an error flag to the granted requester. It sits between the LSU/DMA and DataMemory and is the only driver of DataMemory inputs.

Parameters:
MEM_BYTES, 1024, size of data memory in bytes; any access touching a byte at address >= MEM_BYTES is an error.
RR_EN, 1, 1 = round-robin on contention; 0 = fixed priority, port 0 always wins.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  2  per-port request valid; bit 0 = core, bit 1 = DMA
req_ready  out  2  per-port accept; a request transfers when valid & ready at a clk edge
req_addr0 / req_addr1  in  32  byte address
req_wdata0 / req_wdata1  in  32  store data, right-aligned
req_we  in  2  per-port 1 = store, 0 = load
req_ctrl0 / req_ctrl1  in  3  access size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
resp_valid  out  2  one-cycle response pulse to the granted port
resp_rdata  out  32  load data (0 for stores and errors); shared bus, qualified by resp_valid
resp_err  out  1  misaligned, illegal ctrl or out-of-range; qualified by resp_valid
Address  out  32  to DataMemory
DataWr  out  32  to DataMemory
DMWr  out  1  to DataMemory write enable
DMCtrl  out  3  to DataMemory size control
DataRd  in  32  from DataMemory (combinational read)

Behaviour:
- Reset values: FSM = IDLE, req_ready = 2'b00 during reset, resp_valid = 0, resp_rdata = 0, resp_err = 0, Address = 0, DataWr = 0, DMWr = 0, DMCtrl = 3'b010, last_grant = 1 (port 0 wins first contention).
- FSM states:
  - IDLE: req_ready = 2'b11 masked so that only the selected port sees ready=1; the other port sees 0.
  - ACCESS: req_ready = 00.
  - RESP: req_ready = 00.
- Selection in IDLE:
  - One valid: grant that port.
  - Both valid, RR_EN=1: grant the port that is not last_grant.
  - Both valid, RR_EN=0: grant port 0.
  - last_grant updates on every accept.
- IDLE -> ACCESS on accept (edge k). The request is registered; the error check is computed at accept.
  - Error when ctrl is one of 011/110/111.
  - Error when a half access has addr[0] != 0.
  - Error when a word access has addr[1:0] != 0.
  - Error when addr + size - 1 >= MEM_BYTES.
- ACCESS (cycle k..k+1):
  - Address/DataWr/DMCtrl driven from registered request.
  - DMWr = we & ~err, high for exactly this one cycle.
  - On edge k+1, capture DataRd if load & ~err, else 0. Capture err.
  - Go to RESP.
- RESP (one cycle): resp_valid[granted] = 1, resp_rdata/resp_err valid, DMWr = 0. Always RESP -> IDLE.
- Latency: accept at edge k, resp_valid high in cycle after edge k+2. Maximum throughput is one request per 3 cycles.
- Memory outputs hold their last values in IDLE/RESP. DMWr is never high outside ACCESS.
- Errored requests never write memory, but follow the identical timing.
- A requester may drop or change req_valid at any time without consequence if it was not accepted. Request fields are sampled only at accept.
- Reset mid-operation: DMWr clears immediately (asynchronous), no response is issued for the in-flight request, and the FSM returns to IDLE.
- resp_valid is never asserted on both bits simultaneously.

Test Plan:
- Core store then load: port 0 stores lw addr 12, wdata 0x0000FFFC → DMWr high exactly 1 cycle with Address=12, DMCtrl=010. Then load lw addr 12 → resp_valid[0] 3 cycles after accept, rdata=0x0000FFFC, err=0.
- Contention round-robin, RR_EN=1: both ports valid continuously after reset → grant order 0,1,0,1. Each resp_valid goes only to its own port; never two accepts within 3 cycles.
- Fixed priority, RR_EN=0: both valid for 4 requests → all 4 grants to port 0; port 1 is granted only once port 0 drops valid.
- Errors:
  - lh at addr 13 → resp_err=1, rdata=0, DMWr stays 0.
  - ctrl=011 → err=1.
  - lw at addr MEM_BYTES-2 → err=1.
  - sw at addr 1020 with MEM_BYTES=1024 → err=0.
- Byte access: DMA sb addr 5 data 0xAB, then core lbu addr 5 → rdata=0x000000AB.
- Reset during ACCESS of a store: assert rst mid-cycle → DMWr falls immediately, no resp_valid. After release the first request completes normally.
